cnn_layer_accel_weight_sequencer: RTL

//  Upstream driver of the weight sequence table in the QUAD datapath.

---
 rtl/cnn_layer_accel_weight_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/cnn_layer_accel_weight_sequencer.sv
// Weight sequence driver: walks a rows x passes x SEQ_LEN schedule and emits
// {gray_code, sequence_selector, seq_data_addr} beats for the weight table.
module cnn_layer_accel_weight_sequencer #(
  parameter int SEQ_LEN     = 5,
  parameter int C_CNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [C_CNT_WIDTH-1:0] num_rows,
  input  logic [C_CNT_WIDTH-1:0] num_passes,
  input  logic                   stall,
  output logic [1:0]             gray_code,
  output logic                   sequence_selector,
  output logic [2:0]             seq_data_addr,
  output logic                   seq_valid,
  output logic                   busy,
  output logic                   done
);

  localparam logic [2:0] ADDR_LAST = 3'(SEQ_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_FIN} state_t;

  state_t state, state_next;

  logic [C_CNT_WIDTH-1:0] rows_q, passes_q, row_cnt, pass_cnt;
  logic [2:0]             ptr_addr;
  logic                   ptr_sel;
  logic [1:0]             ptr_gray;

  logic cfg_ok, addr_wrap, pass_last, row_last, last_beat;

  always_comb begin
    cfg_ok    = (num_rows != '0) && (num_passes != '0);
    addr_wrap = (ptr_addr == ADDR_LAST);
    pass_last = (pass_cnt == passes_q - 1'b1);
    row_last  = (row_cnt == rows_q - 1'b1);
    last_beat = addr_wrap && pass_last && row_last;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = cfg_ok ? S_ACTIVE : S_FIN;
      S_ACTIVE: if (!stall && last_beat) state_next = S_FIN;
      S_FIN:    state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // The beat pointer runs one edge ahead of the registered outputs, so a
  // stalled cycle presents the pending (not yet issued) beat with valid low.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q            <= '0;
      passes_q          <= '0;
      row_cnt           <= '0;
      pass_cnt          <= '0;
      ptr_addr          <= '0;
      ptr_sel           <= 1'b1;
      ptr_gray          <= 2'b00;
      gray_code         <= 2'b00;
      sequence_selector <= 1'b1;
      seq_data_addr     <= '0;
      seq_valid         <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      case (state)
        S_ACTIVE: begin
          busy              <= 1'b1;
          done              <= 1'b0;
          seq_valid         <= !stall;
          gray_code         <= ptr_gray;
          sequence_selector <= ptr_sel;
          seq_data_addr     <= ptr_addr;
          if (!stall) begin
            if (addr_wrap) begin
              ptr_addr <= '0;
              if (pass_last) begin
                pass_cnt <= '0;
                ptr_sel  <= 1'b1;
                row_cnt  <= row_cnt + 1'b1;
                ptr_gray <= {ptr_gray[0], ~ptr_gray[1]};
              end else begin
                pass_cnt <= pass_cnt + 1'b1;
                ptr_sel  <= ~ptr_sel;
              end
            end else begin
              ptr_addr <= ptr_addr + 3'd1;
            end
          end
        end
        S_FIN: begin
          done              <= 1'b1;
          busy              <= 1'b0;
          seq_valid         <= 1'b0;
          gray_code         <= 2'b00;
          sequence_selector <= 1'b1;
          seq_data_addr     <= '0;
        end
        default: begin
          done              <= 1'b0;
          busy              <= 1'b0;
          seq_valid         <= 1'b0;
          gray_code         <= 2'b00;
          sequence_selector <= 1'b1;
          seq_data_addr     <= '0;
          if (start && cfg_ok) begin
            rows_q   <= num_rows;
            passes_q <= num_passes;
            row_cnt  <= '0;
            pass_cnt <= '0;
            ptr_addr <= '0;
            ptr_sel  <= 1'b1;
            ptr_gray <= 2'b00;
          end
        end
      endcase
    end
  end

endmodule
